// File: rtl/axi_ram_arbiter_if.sv
// ----------------------------------------------------------------------------
// axi_ram_arbiter_if
//   AXI4 write and read channel bundle between the axi_ram_arbiter (master)
//   and axi_ram (slave). Single-beat use only, but all AXI4 fields the RAM
//   consumes are carried so the bundle drops straight onto axi_ram.
//
//   Modports:
//     master : drives aw*/w*/ar*, bready, rready; observes the slave side
//     slave  : drives awready, wready, b*, arready, r*; observes the master
// ----------------------------------------------------------------------------
interface axi_ram_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
);
    // write address channel
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    // write data channel
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    // write response channel
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    // read address channel
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    // read data channel
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_ram_arbiter.sv
// ----------------------------------------------------------------------------
// axi_ram_arbiter
//   Two-requester front end for axi_ram. Port 0 is instruction fetch, port 1
//   is the data load/store unit. One single-beat AXI4 read or write is in
//   flight at a time; read data / write completion goes back to the winner.
//
//   Ports:
//     clk, rst_n         clock, asynchronous active-low reset
//     req_valid/we[1:0]  per-port request and direction (1 = write)
//     req_addr/wdata/wstrb  per-port payload, slice p belongs to port p
//     req_gnt[1:0]       one-cycle pulse: request of port p captured
//     rsp_valid[1:0]     one-cycle pulse: transaction of port p finished
//     rsp_rdata, rsp_err read data / non-OKAY response, valid with rsp_valid
//     m_axi              AXI4 master side (axi_ram_arbiter_if.master)
//
//   Build option:
//     ARB_ROUND_ROBIN_EN  defined: round-robin with a last-winner register
//                         (reset value 1); undefined: port 1 has fixed
//                         priority over port 0.
// ----------------------------------------------------------------------------
module axi_ram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    input  logic [2*STRB_WIDTH-1:0] req_wstrb,
    output logic [1:0]              req_gnt,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    axi_ram_arbiter_if.master       m_axi
);

    localparam logic [2:0] AX_SIZE  = 3'($clog2(STRB_WIDTH));
    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } state_t;

    state_t state;
    logic   idx;        // index of the requester being served

    // ------------------------------------------------------------------
    // Fixed AXI fields: single beat, full-width, normal bufferable access
    // ------------------------------------------------------------------
    assign m_axi.awlen   = '0;
    assign m_axi.awsize  = AX_SIZE;
    assign m_axi.awburst = BURST_INCR;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = 4'b0011;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.wlast   = 1'b1;
    assign m_axi.arlen   = '0;
    assign m_axi.arsize  = AX_SIZE;
    assign m_axi.arburst = BURST_INCR;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = 4'b0011;

    // IDs and rlast are not needed: only one transaction is ever outstanding
    logic unused_rsp_fields;
    assign unused_rsp_fields = ^{m_axi.bid, m_axi.rid, m_axi.rlast};

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic winner;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_winner;

    always_comb begin
        winner = 1'b0;
        if (req_valid == 2'b11) begin
            winner = ~last_winner;
        end else begin
            winner = req_valid[1];
        end
    end
`else
    always_comb begin
        winner = req_valid[1];
    end
`endif

    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [STRB_WIDTH-1:0] sel_wstrb;

    always_comb begin
        sel_we    = req_we[0];
        sel_addr  = req_addr[ADDR_WIDTH-1:0];
        sel_wdata = req_wdata[DATA_WIDTH-1:0];
        sel_wstrb = req_wstrb[STRB_WIDTH-1:0];
        if (winner) begin
            sel_we    = req_we[1];
            sel_addr  = req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH];
            sel_wdata = req_wdata[2*DATA_WIDTH-1:DATA_WIDTH];
            sel_wstrb = req_wstrb[2*STRB_WIDTH-1:STRB_WIDTH];
        end
    end

    function automatic logic [1:0] port_onehot(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

    // A channel counts as done if it already dropped valid or hands off now
    logic aw_done;
    logic w_done;

    always_comb begin
        aw_done = !m_axi.awvalid || m_axi.awready;
        w_done  = !m_axi.wvalid  || m_axi.wready;
    end

    // ------------------------------------------------------------------
    // Transaction FSM, all outputs registered
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= 1'b0;
            req_gnt       <= '0;
            rsp_valid     <= '0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            m_axi.awid    <= '0;
            m_axi.awaddr  <= '0;
            m_axi.awvalid <= 1'b0;
            m_axi.wdata   <= '0;
            m_axi.wstrb   <= '0;
            m_axi.wvalid  <= 1'b0;
            m_axi.bready  <= 1'b0;
            m_axi.arid    <= '0;
            m_axi.araddr  <= '0;
            m_axi.arprot  <= '0;
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_winner   <= 1'b1;
`endif
        end else begin
            req_gnt   <= '0;
            rsp_valid <= '0;

            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        idx     <= winner;
                        req_gnt <= port_onehot(winner);
`ifdef ARB_ROUND_ROBIN_EN
                        last_winner <= winner;
`endif
                        if (sel_we) begin
                            m_axi.awid    <= ID_WIDTH'(winner);
                            m_axi.awaddr  <= sel_addr;
                            m_axi.wdata   <= sel_wdata;
                            m_axi.wstrb   <= sel_wstrb;
                            m_axi.awvalid <= 1'b1;
                            m_axi.wvalid  <= 1'b1;
                            state         <= WR_REQ;
                        end else begin
                            m_axi.arid    <= ID_WIDTH'(winner);
                            m_axi.araddr  <= sel_addr;
                            m_axi.arprot  <= winner ? 3'b000 : 3'b100;
                            m_axi.arvalid <= 1'b1;
                            state         <= RD_ADDR;
                        end
                    end
                end

                RD_ADDR: begin
                    if (m_axi.arready) begin
                        m_axi.arvalid <= 1'b0;
                        m_axi.rready  <= 1'b1;
                        state         <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (m_axi.rvalid && m_axi.rready) begin
                        rsp_rdata    <= m_axi.rdata;
                        rsp_err      <= |m_axi.rresp;
                        m_axi.rready <= 1'b0;
                        rsp_valid    <= port_onehot(idx);
                        state        <= DONE;
                    end
                end

                WR_REQ: begin
                    if (m_axi.awvalid && m_axi.awready) begin
                        m_axi.awvalid <= 1'b0;
                    end
                    if (m_axi.wvalid && m_axi.wready) begin
                        m_axi.wvalid <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        m_axi.bready <= 1'b1;
                        state        <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (m_axi.bvalid && m_axi.bready) begin
                        rsp_err      <= |m_axi.bresp;
                        m_axi.bready <= 1'b0;
                        rsp_valid    <= port_onehot(idx);
                        state        <= DONE;
                    end
                end

                // rsp_valid was raised on entry, so it is high for this cycle only
                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axi_ram_arbiter
//   Directed bench for axi_ram_arbiter. A small AXI slave with a word memory
//   and per-channel ready/valid delays stands in for axi_ram; it updates on
//   the falling edge. Expected values are hand-derived for that slave.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_ram_arbiter;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = 4;
    localparam int IW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]      req_valid;
    logic [1:0]      req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [2*SW-1:0] req_wstrb;
    logic [1:0]      req_gnt;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;

    axi_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW)) axi ();

    axi_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .req_gnt   (req_gnt),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .m_axi     (axi)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- slave model ----------------
    int ar_delay, r_delay, aw_delay, w_delay, b_delay;
    logic [1:0] r_resp_cfg, b_resp_cfg;
    logic [31:0] mem [256];

    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic r_pend, r_fire, aw_got, w_got, b_pend, b_fire;
    logic [IW-1:0] cap_arid, cap_awid;
    logic [AW-1:0] cap_araddr, cap_awaddr;
    logic [2:0]    cap_arprot, cap_awprot;
    logic [DW-1:0] cap_wdata;
    logic [SW-1:0] cap_wstrb;

    task automatic slave_reset();
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid = 1'b0; axi.bid = '0; axi.bresp = '0;
        axi.rvalid = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        r_pend = 0; r_fire = 0; aw_got = 0; w_got = 0; b_pend = 0; b_fire = 0;
    endtask

    task automatic slave_step();
        logic [7:0] wi;
        // read address
        if (axi.arready) begin
            axi.arready = 1'b0; r_pend = 1'b1; r_cnt = 0;
        end else if (axi.arvalid && !r_pend) begin
            if (ar_cnt >= ar_delay) begin
                axi.arready = 1'b1; ar_cnt = 0;
                cap_arid = axi.arid; cap_araddr = axi.araddr; cap_arprot = axi.arprot;
            end else ar_cnt++;
        end
        // read data
        if (r_fire) begin
            axi.rvalid = 1'b0; axi.rdata = 32'hBAD0BAD0; r_pend = 1'b0; r_fire = 1'b0;
        end else if (r_pend) begin
            if (!axi.rvalid) begin
                if (r_cnt >= r_delay) begin
                    axi.rvalid = 1'b1; axi.rdata = mem[cap_araddr[9:2]];
                    axi.rresp = r_resp_cfg; axi.rid = cap_arid; axi.rlast = 1'b1;
                end else r_cnt++;
            end
            if (axi.rvalid && axi.rready) r_fire = 1'b1;
        end
        // write address
        if (axi.awready) begin
            axi.awready = 1'b0; aw_got = 1'b1;
        end else if (axi.awvalid && !aw_got) begin
            if (aw_cnt >= aw_delay) begin
                axi.awready = 1'b1; aw_cnt = 0;
                cap_awid = axi.awid; cap_awaddr = axi.awaddr; cap_awprot = axi.awprot;
            end else aw_cnt++;
        end
        // write data
        if (axi.wready) begin
            axi.wready = 1'b0; w_got = 1'b1;
        end else if (axi.wvalid && !w_got) begin
            if (w_cnt >= w_delay) begin
                axi.wready = 1'b1; w_cnt = 0;
                cap_wdata = axi.wdata; cap_wstrb = axi.wstrb;
            end else w_cnt++;
        end
        if (aw_got && w_got) begin
            wi = cap_awaddr[9:2];
            for (int b = 0; b < SW; b++)
                if (cap_wstrb[b]) mem[wi][8*b +: 8] = cap_wdata[8*b +: 8];
            aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1; b_cnt = 0;
        end
        // write response
        if (b_fire) begin
            axi.bvalid = 1'b0; b_pend = 1'b0; b_fire = 1'b0;
        end else if (b_pend) begin
            if (!axi.bvalid) begin
                if (b_cnt >= b_delay) begin
                    axi.bvalid = 1'b1; axi.bresp = b_resp_cfg; axi.bid = cap_awid;
                end else b_cnt++;
            end
            if (axi.bvalid && axi.bready) b_fire = 1'b1;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[4] = 32'hDEADBEEF;
        mem[8] = 32'hAABBCCDD;
        slave_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) slave_reset();
            else slave_step();
        end
    end

    // ---------------- passive monitor ----------------
    int gnt_cnt = 0, rsp_cnt0 = 0, rsp_cnt1 = 0;
    int arv_cnt = 0, awv_cnt = 0, wv_cnt = 0, rrdy_cnt = 0, brdy_cnt = 0;
    logic gnt_log [64];

    always @(negedge clk) begin
        if (req_gnt != 2'b00) begin
            gnt_log[gnt_cnt % 64] = req_gnt[1];
            gnt_cnt++;
        end
        if (rsp_valid[0]) rsp_cnt0++;
        if (rsp_valid[1]) rsp_cnt1++;
        if (axi.arvalid) arv_cnt++;
        if (axi.awvalid) awv_cnt++;
        if (axi.wvalid)  wv_cnt++;
        if (axi.rready)  rrdy_cnt++;
        if (axi.bready)  brdy_cnt++;
    end

    // ---------------- requester driver ----------------
    int            g_lat, r_lat, pulses;
    logic [DW-1:0] r_data;
    logic          r_err;

    task automatic xact(input int p, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [SW-1:0] ws);
        int n;
        int base;
        base = (p == 0) ? rsp_cnt0 : rsp_cnt1;
        @(negedge clk);
        req_valid[p] = 1'b1;
        req_we[p] = we;
        req_addr[p*AW +: AW] = addr;
        req_wdata[p*DW +: DW] = wd;
        req_wstrb[p*SW +: SW] = ws;
        g_lat = -1; r_lat = -1; r_data = '0; r_err = 1'b0; n = 0;
        while (n < 100 && g_lat < 0) begin
            @(negedge clk); n++;
            if (req_gnt[p]) g_lat = n;
        end
        req_valid[p] = 1'b0;
        while (n < 200 && r_lat < 0) begin
            @(negedge clk); n++;
            if (rsp_valid[p]) begin
                r_lat = n; r_data = rsp_rdata; r_err = rsp_err;
            end
        end
        repeat (2) @(negedge clk);
        #1;
        pulses = ((p == 0) ? rsp_cnt0 : rsp_cnt1) - base;
    endtask

    // ---------------- directed sequence ----------------
    int   snap_a, snap_b, g0, c0, n;
    logic exp_w;

    initial begin
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0;
        r_resp_cfg = 2'b00; b_resp_cfg = 2'b00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ctrl", {24'h0, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready,
                           axi.bready, req_gnt[0], rsp_valid}, 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_addr", {axi.araddr, axi.awaddr}, 32'h0);
        check("rst_ids", {16'h0, axi.arid, axi.awid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // port 0 read of word 4
        xact(0, 1'b0, 16'h0010, 32'h0, 4'h0);
        check("rd0_gnt_lat", g_lat, 1);
        check("rd0_rsp_lat", r_lat, 3);
        check("rd0_data", r_data, 32'hDEADBEEF);
        check("rd0_err", {31'h0, r_err}, 0);
        check("rd0_arid", {24'h0, cap_arid}, 0);
        check("rd0_arprot", {29'h0, cap_arprot}, 32'h4);
        check("rd0_araddr", {16'h0, cap_araddr}, 32'h10);
        check("rd0_pulses", pulses, 1);

        // port 1 partial write then readback
        xact(1, 1'b1, 16'h0020, 32'h12345678, 4'b0011);
        check("wr1_gnt_lat", g_lat, 1);
        check("wr1_rsp_lat", r_lat, 3);
        check("wr1_err", {31'h0, r_err}, 0);
        check("wr1_awid", {24'h0, cap_awid}, 1);
        check("wr1_awprot", {29'h0, cap_awprot}, 0);
        check("wr1_awaddr", {16'h0, cap_awaddr}, 32'h20);
        check("wr1_pulses", pulses, 1);
        xact(1, 1'b0, 16'h0020, 32'h0, 4'h0);
        check("rb1_data", r_data, 32'hAABB5678);
        check("rb1_arprot", {29'h0, cap_arprot}, 0);
        check("rb1_arid", {24'h0, cap_arid}, 1);

        // both ports read continuously for six grants
        g0 = gnt_cnt; c0 = rsp_cnt0 + rsp_cnt1;
        @(negedge clk);
        req_we = 2'b00;
        req_addr = {16'h0020, 16'h0010};
        req_valid = 2'b11;
        n = 0;
        while (n < 300 && gnt_cnt - g0 < 6) begin @(negedge clk); #1; n++; end
        req_valid = 2'b00;
        n = 0;
        while (n < 100 && rsp_cnt0 + rsp_cnt1 - c0 < 6) begin @(negedge clk); #1; n++; end
        check("arb_grants", gnt_cnt - g0, 6);
        for (int i = 0; i < 6; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_w = (i % 2 == 0) ? 1'b0 : 1'b1;
`else
            exp_w = 1'b1;
`endif
            check($sformatf("arb_order%0d", i), {31'h0, gnt_log[(g0 + i) % 64]}, {31'h0, exp_w});
        end
        check("arb_rsps", rsp_cnt0 + rsp_cnt1 - c0, 6);

        // arready stalled five cycles
        ar_delay = 5;
        snap_a = arv_cnt;
        xact(0, 1'b0, 16'h0010, 32'h0, 4'h0);
        check("arstall_arvalid", arv_cnt - snap_a, 6);
        check("arstall_rsp_lat", r_lat, 8);
        check("arstall_data", r_data, 32'hDEADBEEF);
        check("arstall_pulses", pulses, 1);
        ar_delay = 0;

        // awready stalled three cycles, wready immediate
        aw_delay = 3;
        snap_a = awv_cnt; snap_b = wv_cnt;
        xact(1, 1'b1, 16'h0024, 32'hCAFEF00D, 4'hF);
        check("awstall_awvalid", awv_cnt - snap_a, 4);
        check("awstall_wvalid", wv_cnt - snap_b, 1);
        check("awstall_rsp_lat", r_lat, 6);
        check("awstall_pulses", pulses, 1);
        check("awstall_mem", mem[9], 32'hCAFEF00D);
        aw_delay = 0;

        // rvalid delayed four cycles
        r_delay = 4;
        snap_a = rrdy_cnt;
        xact(0, 1'b0, 16'h0020, 32'h0, 4'h0);
        check("rdly_rready", rrdy_cnt - snap_a, 5);
        check("rdly_rsp_lat", r_lat, 7);
        check("rdly_data", r_data, 32'hAABB5678);
        check("rdly_pulses", pulses, 1);
        repeat (3) @(negedge clk);
        check("rdly_hold", rsp_rdata, 32'hAABB5678);
        r_delay = 0;

        // bvalid delayed four cycles with SLVERR
        b_delay = 4; b_resp_cfg = 2'b10;
        snap_a = brdy_cnt;
        xact(1, 1'b1, 16'h0028, 32'h0, 4'hF);
        check("bdly_bready", brdy_cnt - snap_a, 5);
        check("bdly_rsp_lat", r_lat, 7);
        check("bdly_err", {31'h0, r_err}, 1);
        check("bdly_pulses", pulses, 1);
        check("bdly_rdata_kept", rsp_rdata, 32'hAABB5678);
        b_delay = 0; b_resp_cfg = 2'b00;

        // read error response
        r_resp_cfg = 2'b10;
        xact(0, 1'b0, 16'h0010, 32'h0, 4'h0);
        check("rerr_err", {31'h0, r_err}, 1);
        check("rerr_data", r_data, 32'hDEADBEEF);
        r_resp_cfg = 2'b00;

        // asynchronous reset while waiting in RD_DATA
        r_delay = 10;
        @(negedge clk);
        req_we[0] = 1'b0; req_addr[15:0] = 16'h0010; req_valid[0] = 1'b1;
        n = 0;
        while (n < 20 && !axi.rready) begin
            @(negedge clk); n++;
            if (req_gnt[0]) req_valid[0] = 1'b0;
        end
        req_valid[0] = 1'b0;
        check("mid_rready", {31'h0, axi.rready}, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ctrl", {24'h0, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready,
                            axi.bready, req_gnt[0], rsp_valid}, 32'h0);
        check("arst_rdata", rsp_rdata, 32'h0);
        check("arst_err", {31'h0, rsp_err}, 0);
        r_delay = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        xact(0, 1'b0, 16'h0010, 32'h0, 4'h0);
        check("post_rst_gnt_lat", g_lat, 1);
        check("post_rst_rsp_lat", r_lat, 3);
        check("post_rst_data", r_data, 32'hDEADBEEF);
        check("post_rst_pulses", pulses, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_ram_arbiter.md
Name: axi_ram_arbiter

Overview:
Two-requester front end for the shared axi_ram, acting as its single AXI4 master. Port 0 is the instruction fetch and port 1 is the data load/store unit of the scoreboard core. The block accepts simple single-word requests, arbitrates between them and issues one single-beat AXI4 read or write at a time. It returns read data or write completion to the winning requester.

Parameters:
DATA_WIDTH, 32, data bus width; must match axi_ram.
ADDR_WIDTH, 16, byte address width.
STRB_WIDTH, DATA_WIDTH/8, write strobe width.
ID_WIDTH, 8, AXI ID width; issued ID = requester index, zero-extended.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
req_valid  in  2  bit p = requester p has a pending request.
req_we  in  2  bit p: 1 = write, 0 = read.
req_addr  in  2*ADDR_WIDTH  slice p = byte address (word aligned).
req_wdata  in  2*DATA_WIDTH  slice p = write data.
req_wstrb  in  2*STRB_WIDTH  slice p = byte enables.
req_gnt  out  2  one-cycle pulse: request p captured.
rsp_valid  out  2  one-cycle pulse: transaction for p completed.
rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid.
rsp_err  out  1  resp != OKAY; valid with rsp_valid.
m_axi_aw*/w*/b*  mixed  AXI4  full write channels to axi_ram.
m_axi_ar*/r*  mixed  AXI4  full read channels to axi_ram.

Behaviour:
- Constant AXI fields: awlen/arlen = 0; awsize/arsize = $clog2(STRB_WIDTH); burst = INCR; lock = 0; cache = 4'b0011; wlast = 1.
- AXI prot: arprot = 3'b100 for port 0, 3'b000 for port 1; awprot = 3'b000.
- All outputs are registered.
- Reset values: every valid/ready/gnt/rsp output = 0; rsp_rdata = 0; rsp_err = 0; aw/ar addr and id = 0; state = IDLE.
- Reset is asynchronous and takes effect mid-transaction. Any in-flight AXI transaction is abandoned, and axi_ram is reset with the core.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE, any req_valid: winner chosen (see Optional Feature).
  - Next edge: winner's addr/wdata/wstrb/we and index latched; req_gnt[winner] pulses one cycle.
  - Next edge also goes to RD_ADDR (arvalid = 1) or WR_REQ (awvalid = 1, wvalid = 1).
- Requester handshake: hold req_valid and payload stable until req_gnt. The requester may drop or change them from the cycle after gnt. Payload is not sampled again.
- RD_ADDR: arvalid held until arready. On handshake, arvalid = 0, rready = 1, go to RD_DATA.
- RD_DATA: on rvalid & rready:
  - latch rdata into rsp_rdata; rsp_err = (rresp != 0);
  - rready = 0; go to DONE.
  - rlast is not checked.
- WR_REQ: awvalid and wvalid drop independently on their own handshake.
  - Both handshakes may land in the same cycle or in either order.
  - When both are complete, bready = 1, go to WR_RESP.
- WR_RESP: on bvalid & bready, rsp_err = (bresp != 0), bready = 0, go to DONE.
- DONE: rsp_valid[index] pulses for exactly one cycle; then return to IDLE.
  - rsp_rdata holds its value until the next read completes.
- Best-case latency against axi_ram (request seen in cycle 0):
  - read: gnt at cycle 1, rsp_valid at cycle 5;
  - write: gnt at cycle 1, rsp_valid at cycle 6.
- Only one transaction is outstanding at a time. Requests arriving outside IDLE wait; req_valid is re-sampled in IDLE only.
- A requester may present a new request in the DONE cycle; it is arbitrated in the following IDLE cycle.
- No address checking; the address is passed through unmodified.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: round-robin. A 1-bit last-winner register resets to 1 and updates at each grant. On simultaneous requests the port that is not the last winner wins; a single requester always wins.
- Undefined: fixed priority, port 1 (data) over port 0 (fetch); no last-winner register.

Test Plan:
- Port 0 read, addr 0x0010, RAM word 4 = 0xDEADBEEF -> gnt[0] at cycle 1; arid = 0, arprot = 3'b100; rsp_valid[0] with rdata 0xDEADBEEF, err 0.
- Port 1 write, addr 0x0020, wdata 0x12345678, wstrb 4'b0011 -> bid = 1, rsp_valid[1]; a follow-up read returns 0x????5678 with the upper bytes unchanged.
- Both ports request reads continuously for 6 transactions:
  - with ARB_ROUND_ROBIN_EN, grant order is 0,1,0,1,0,1 (last-winner reset = 1);
  - without it, all 6 grants go to port 1 while it requests.
- Slave stalls: arready held low 5 cycles, awready low 3 cycles with wready immediate -> arvalid/awvalid held, wvalid drops after 1 cycle, no rsp_valid until b handshake, exactly one rsp pulse.
- bvalid and rvalid delayed 4 cycles -> bready/rready stay high throughout; rsp_valid exactly 1 cycle after handshake; rsp_rdata stable afterwards.
- rst_n low during RD_DATA -> all valids/readies/gnt/rsp at 0 asynchronously; after release, a fresh port 0 read completes correctly.
